// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues imem reads from pc, holds the fetched word
// until the consumer accepts it, then redirects or advances pc.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [4:0]  op,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID,
    S_ERROR
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      pc_out_q <= 32'h0;
      cnt_q    <= 8'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    next_pc  = pc_q + 32'd4;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        cnt_d   = 8'h0;
      end
      S_FETCH: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          cnt_d    = 8'h0;
          state_d  = S_VALID;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          if (pcsrc)     next_pc = branch_target;
          else if (jump) next_pc = jump_target;
          // A misaligned redirect is fatal and leaves pc where it was.
          if (next_pc[1:0] != 2'b00) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_ERROR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_VALID);
  assign instr       = instr_q;
  assign op          = instr_q[31:27];
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + 32'd4;
  assign err         = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random fetch/accept traffic
// checked against an address-sequence model of the fetch stream.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default parameters
  logic        rst_n, ack, ready, pcsrc, jump;
  logic [31:0] rdata, btgt, jtgt;
  logic        req, ivalid, err;
  logic [31:0] addr, instr, pc_out, pc_plus4;
  logic [4:0]  op;

  // Instance 1: wrap-around reset address
  logic        rst1_n, ack1, ready1, pcsrc1, jump1;
  logic [31:0] rdata1, btgt1, jtgt1;
  logic        req1, ivalid1, err1;
  logic [31:0] addr1, instr1, pc_out1, pc_plus41;
  logic [4:0]  op1;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit u0 (
    .clk(clk), .rst_n(rst_n), .imem_req(req), .imem_addr(addr), .imem_ack(ack),
    .imem_rdata(rdata), .instr_valid(ivalid), .instr_ready(ready), .instr(instr),
    .op(op), .pc_out(pc_out), .pc_plus4(pc_plus4), .pcsrc(pcsrc), .jump(jump),
    .branch_target(btgt), .jump_target(jtgt), .err(err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(4)) u1 (
    .clk(clk), .rst_n(rst1_n), .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1),
    .imem_rdata(rdata1), .instr_valid(ivalid1), .instr_ready(ready1), .instr(instr1),
    .op(op1), .pc_out(pc_out1), .pc_plus4(pc_plus41), .pcsrc(pcsrc1), .jump(jump1),
    .branch_target(btgt1), .jump_target(jtgt1), .err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_pc, r, held_instr, held_pc;
  logic        p, j;
  int          w, h;

  initial begin
    rst_n = 1'b0; ack = 1'b0; ready = 1'b0; pcsrc = 1'b0; jump = 1'b0;
    rdata = 32'h0; btgt = 32'h0; jtgt = 32'h0;
    rst1_n = 1'b0; ack1 = 1'b0; ready1 = 1'b0; pcsrc1 = 1'b0; jump1 = 1'b0;
    rdata1 = 32'h0; btgt1 = 32'h0; jtgt1 = 32'h0;

    // Reset state
    repeat (2) step();
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_valid", {31'h0, ivalid}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);

    // Release: one IDLE cycle, then FETCH from RESET_PC
    rst_n = 1'b1;
    chk("idle_req", {31'h0, req}, 32'h0);
    step();
    chk("first_req", {31'h0, req}, 32'h1);
    chk("first_addr", addr, 32'h0);
    ack = 1'b1; rdata = 32'h2000_0001;
    step();
    ack = 1'b0;
    chk("first_valid", {31'h0, ivalid}, 32'h1);
    chk("first_instr", instr, 32'h2000_0001);
    chk("first_op", {27'h0, op}, 32'h4);
    chk("first_pc_plus4", pc_plus4, 32'h4);
    chk("first_req_low", {31'h0, req}, 32'h0);

    // Hold 5 cycles; stray ack and redirect inputs must be ignored
    for (int i = 0; i < 5; i++) begin
      ack = 1'b1; rdata = 32'hDEAD_BEEF; pcsrc = 1'b1; btgt = 32'h0000_0013;
      step();
      chk("hold_valid", {31'h0, ivalid}, 32'h1);
      chk("hold_instr", instr, 32'h2000_0001);
      chk("hold_pc_out", pc_out, 32'h0);
      chk("hold_req", {31'h0, req}, 32'h0);
    end
    ack = 1'b0; pcsrc = 1'b0; ready = 1'b1;
    step();
    ready = 1'b0;
    chk("seq_req", {31'h0, req}, 32'h1);
    chk("seq_addr", addr, 32'h4);
    chk("seq_err", {31'h0, err}, 32'h0);

    // Back-to-back: ack in first FETCH cycle, accept in first VALID cycle
    ack = 1'b1; rdata = 32'h1234_5678;
    step();
    ack = 1'b0;
    chk("b2b_valid", {31'h0, ivalid}, 32'h1);
    chk("b2b_pc_out", pc_out, 32'h4);
    ready = 1'b1; pcsrc = 1'b1; jump = 1'b1; btgt = 32'h40; jtgt = 32'h80;
    step();
    ready = 1'b0; pcsrc = 1'b0; jump = 1'b0;
    chk("prio_req", {31'h0, req}, 32'h1);
    chk("prio_addr", addr, 32'h40);

    // Random traffic against the fetch-address model
    exp_pc = 32'h40;
    for (int t = 0; t < 25; t++) begin
      w = $urandom_range(0, 4);
      for (int k = 0; k < w; k++) begin
        chk("rnd_wait_req", {31'h0, req}, 32'h1);
        chk("rnd_wait_addr", addr, exp_pc);
        step();
      end
      chk("rnd_req", {31'h0, req}, 32'h1);
      chk("rnd_addr", addr, exp_pc);
      r = $urandom;
      ack = 1'b1; rdata = r;
      step();
      ack = 1'b0;
      held_instr = r; held_pc = exp_pc;
      h = $urandom_range(0, 3);
      for (int k = 0; k <= h; k++) begin
        chk("rnd_valid", {31'h0, ivalid}, 32'h1);
        chk("rnd_instr", instr, held_instr);
        chk("rnd_op", {27'h0, op}, held_instr >> 27);
        chk("rnd_pc_out", pc_out, held_pc);
        chk("rnd_pc_plus4", pc_plus4, held_pc + 32'd4);
        chk("rnd_err", {31'h0, err}, 32'h0);
        if (k < h) begin
          pcsrc = $urandom_range(0, 1); jump = $urandom_range(0, 1);
          btgt = $urandom; jtgt = $urandom; ack = $urandom_range(0, 1); rdata = $urandom;
          step();
          ack = 1'b0;
        end
      end
      p = $urandom_range(0, 1); j = $urandom_range(0, 1);
      btgt = $urandom & 32'hFFFF_FFFC; jtgt = $urandom & 32'hFFFF_FFFC;
      pcsrc = p; jump = j; ready = 1'b1;
      exp_pc = p ? btgt : (j ? jtgt : exp_pc + 32'd4);
      step();
      ready = 1'b0; pcsrc = 1'b0; jump = 1'b0;
    end

    // Misaligned jump on accept is fatal
    ack = 1'b1; rdata = 32'h0BAD_0000;
    step();
    ack = 1'b0;
    chk("mis_valid", {31'h0, ivalid}, 32'h1);
    ready = 1'b1; jump = 1'b1; jtgt = 32'h82;
    step();
    ready = 1'b0; jump = 1'b0;
    chk("mis_err", {31'h0, err}, 32'h1);
    chk("mis_req", {31'h0, req}, 32'h0);
    chk("mis_valid_low", {31'h0, ivalid}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      ack = 1'b1; ready = 1'b1;
      step();
      chk("err_stuck_req", {31'h0, req}, 32'h0);
      chk("err_stuck_err", {31'h0, err}, 32'h1);
    end
    ack = 1'b0; ready = 1'b0;

    // Asynchronous reset clears the error without a clock edge
    rst_n = 1'b0;
    #1;
    chk("arst_err", {31'h0, err}, 32'h0);
    chk("arst_instr", instr, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("to_req", {31'h0, req}, 32'h1);
    for (int k = 1; k < 16; k++) begin
      step();
      chk("to_wait_req", {31'h0, req}, 32'h1);
      chk("to_wait_err", {31'h0, err}, 32'h0);
    end
    step();
    chk("to_err", {31'h0, err}, 32'h1);
    chk("to_req_low", {31'h0, req}, 32'h0);
    ack = 1'b1; rdata = 32'hFFFF_0000;
    step();
    ack = 1'b0;
    chk("late_ack_valid", {31'h0, ivalid}, 32'h0);
    chk("late_ack_instr", instr, 32'h0);
    chk("late_ack_err", {31'h0, err}, 32'h1);

    // Wrap-around instance
    rst1_n = 1'b1;
    step();
    chk("wrap_req", {31'h0, req1}, 32'h1);
    chk("wrap_addr", addr1, 32'hFFFF_FFFC);
    ack1 = 1'b1; rdata1 = 32'hA5A5_5A5A;
    step();
    ack1 = 1'b0;
    chk("wrap_pc_out", pc_out1, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus41, 32'h0);
    ready1 = 1'b1;
    step();
    ready1 = 1'b0;
    chk("wrap_next_addr", addr1, 32'h0);
    chk("wrap_next_req", {31'h0, req1}, 32'h1);
    chk("wrap_err", {31'h0, err1}, 32'h0);

    // Mid-FETCH reset, then a late ack lands in IDLE
    rst1_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, req1}, 32'h0);
    chk("mid_rst_valid", {31'h0, ivalid1}, 32'h0);
    chk("mid_rst_instr", instr1, 32'h0);
    chk("mid_rst_pc_out", pc_out1, 32'h0);
    ack1 = 1'b1; rdata1 = 32'h7777_7777;
    step();
    rst1_n = 1'b1;
    chk("idle_ack_valid", {31'h0, ivalid1}, 32'h0);
    step();
    ack1 = 1'b0;
    chk("post_rst_req", {31'h0, req1}, 32'h1);
    chk("post_rst_addr", addr1, 32'hFFFF_FFFC);
    chk("post_rst_valid", {31'h0, ivalid1}, 32'h0);
    chk("post_rst_instr", instr1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] are 0.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles spent waiting for imem_ack, range 2..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  read address; equals pc while imem_req=1.
REQ-007 imem_ack  input  1  read data valid this cycle.
REQ-008 imem_rdata  input  32  instruction word, sampled when imem_ack=1.
REQ-009 instr_valid  output  1  instr, op and pc_out hold a fetched instruction.
REQ-010 instr_ready  input  1  consumer accepts the instruction this cycle.
REQ-011 instr  output  32  fetched instruction word.
REQ-012 op  output  5  instr[31:27]; feeds the controller opcode input.
REQ-013 pc_out  output  32  address of instr.
REQ-014 pc_plus4  output  32  pc_out+4, modulo 2^32.
REQ-015 pcsrc  input  1  take branch_target; sampled only on accept.
REQ-016 jump  input  1  take jump_target; sampled only on accept.
REQ-017 branch_target  input  32  branch destination.
REQ-018 jump_target  input  32  jump destination.
REQ-019 err  output  1  sticky fault flag.

Function
REQ-020 FSM states: IDLE, FETCH, VALID, ERROR; encoding is free.
REQ-021 IDLE: outputs idle; moves to FETCH on the next edge.
REQ-022 FETCH: imem_req=1, imem_addr=pc; counter increments each cycle without ack.
REQ-023 FETCH with imem_ack=1: instr<=imem_rdata, pc_out<=pc, counter<=0, state->VALID, so instr_valid=1 one cycle after ack.
REQ-024 FETCH with counter reaching TIMEOUT-1 and no ack: state->ERROR, err<=1.
REQ-025 VALID: instr_valid=1, imem_req=0; instr, op and pc_out are held stable until accept.
REQ-026 Accept means instr_valid=1 and instr_ready=1 in the same cycle.
REQ-027 On accept, next pc has priority pcsrc > jump > pc+4; state->FETCH.
REQ-028 pcsrc=1 and jump=1 together on accept: branch_target wins.
REQ-029 On accept with a selected target whose bits [1:0] are nonzero: state->ERROR, err<=1, pc unchanged.
REQ-030 Sequential increment from pc=32'hFFFF_FFFC wraps to 32'h0000_0000 without error.
REQ-031 pcsrc, jump and the targets are ignored whenever no accept occurs.
REQ-032 imem_ack outside FETCH is ignored; it captures no data and changes no state.
REQ-033 ERROR is terminal: imem_req=0, instr_valid=0, err=1 until reset.
REQ-034 Minimum throughput is one instruction per 2 cycles (ack in the first FETCH cycle, accept in the first VALID cycle).

Reset
REQ-035 rst_n=0 asynchronously forces state=IDLE, pc=RESET_PC, counter=0, imem_req=0, instr_valid=0, err=0, instr=0, pc_out=0.
REQ-036 Reset during a FETCH discards the outstanding request; a late ack arrives in IDLE and is ignored.
REQ-037 After rst_n is released, the first imem_req rises in the second rising edge's cycle (IDLE, then FETCH).

Verification
REQ-038 Reset release, ack on the first request with rdata=32'h2000_0001 -> imem_addr=0, instr_valid next cycle, op=5'b00100, pc_plus4=4.
REQ-039 Hold instr_ready=0 for 5 cycles in VALID -> instr and pc_out stable, imem_req=0; accept without redirect -> next imem_addr=4.
REQ-040 Accept with pcsrc=1, jump=1, branch_target=32'h40, jump_target=32'h80 -> next imem_addr=32'h40.
REQ-041 Accept with jump=1, jump_target=32'h82 -> err=1, ERROR state, no further imem_req until reset.
REQ-042 No ack for TIMEOUT cycles -> err=1 on the timeout edge; a later ack is ignored.
REQ-043 RESET_PC=32'hFFFF_FFFC, accept without redirect -> next imem_addr=0, pc_plus4 of the first instruction=0; a mid-FETCH reset returns outputs to their reset values immediately.
